// File: rtl/lcd_pkg.sv
// Shared state encoding, command constants and init ROM for the LCD bus scheduler.
// The init ROM exists only when LCD_SCHED_INIT_EN is defined.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_INIT_WAIT = 3'd0,
        ST_INIT_CMD  = 3'd1,
        ST_IDLE      = 3'd2,
        ST_SETUP     = 3'd3,
        ST_STROBE    = 3'd4,
        ST_HOLD      = 3'd5,
        ST_EXEC      = 3'd6
    } lcd_sched_state_t;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
    localparam int         LCD_INIT_LEN  = 4;

`ifdef LCD_SCHED_INIT_EN
    localparam logic [7:0] LCD_INIT_SEQ [0:LCD_INIT_LEN-1] = '{8'h38, 8'h0C, 8'h01, 8'h06};
`endif

    // Clear and home are the only instructions needing the long execution wait.
    function automatic logic lcd_is_slow_cmd(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_bus_scheduler_arbiter.sv
// Two-way round-robin arbiter; a grant is an accept, so the pointer
// always moves past whichever port was just granted.
module lcd_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection and next pointer (0 = port A, 1 = port B).
    always_comb begin
        grant = 2'b00;
        ptr_d = ptr_q;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end else begin
            grant = 2'b00;
        end
        if (grant[0]) begin
            ptr_d = 1'b1;
        end else if (grant[1]) begin
            ptr_d = 1'b0;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// HD44780 bus sequencer shared by two writers. Define LCD_SCHED_INIT_EN to
// compile in the power-on wait and the four-command init sequence.
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC     = 2,
    parameter int E_HIGH_CYC    = 12,
    parameter int HOLD_CYC      = 1,
    parameter int EXEC_CYC      = 960,
    parameter int CLEAR_CYC     = 39360,
    parameter int INIT_WAIT_CYC = 360000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_valid,
    input  logic       a_rs,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic       b_rs,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic [7:0] d,
    output logic       e,
    output logic       rs,
    output logic       busy,
    output logic       init_done
);

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, E_HIGH_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                  max2(CLEAR_CYC, INIT_WAIT_CYC));
    localparam int CW = $clog2(MAX_CYC) + 1;

`ifdef LCD_SCHED_INIT_EN
    localparam lcd_sched_state_t RESET_ST  = ST_INIT_WAIT;
    localparam int               RESET_CNT = INIT_WAIT_CYC - 1;
`else
    localparam lcd_sched_state_t RESET_ST  = ST_IDLE;
    localparam int               RESET_CNT = 0;
`endif

    // The counter is loaded with N-1 on entry so a state lasts exactly N cycles.
    function automatic logic [CW-1:0] cyc_load(input int n);
        return CW'(n - 1);
    endfunction

    lcd_sched_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       d_q, d_d;
    logic             rs_q, rs_d;
    logic             e_q, e_d;
    logic             busy_q, busy_d;
    logic             init_done_q, init_done_d;
    logic [1:0]       grant_s;
`ifdef LCD_SCHED_INIT_EN
    logic [1:0]       idx_q, idx_d;
`endif

    lcd_rr_arbiter u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({b_valid, a_valid}),
        .enable ((state_q == ST_IDLE) && init_done_q),
        .grant  (grant_s)
    );

    assign a_ready   = grant_s[0];
    assign b_ready   = grant_s[1];
    assign d         = d_q;
    assign rs        = rs_q;
    assign e         = e_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;

    // Next-state, counter and bus-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        d_d         = d_q;
        rs_d        = rs_q;
        e_d         = e_q;
`ifdef LCD_SCHED_INIT_EN
        init_done_d = init_done_q;
        idx_d       = idx_q;
`else
        init_done_d = 1'b1;
`endif
        case (state_q)
`ifdef LCD_SCHED_INIT_EN
            ST_INIT_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_INIT_CMD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_INIT_CMD: begin
                d_d     = LCD_INIT_SEQ[idx_q];
                rs_d    = 1'b0;
                state_d = ST_SETUP;
                cnt_d   = cyc_load(SETUP_CYC);
            end
`endif
            ST_IDLE: begin
                if (grant_s[1]) begin
                    d_d     = b_data;
                    rs_d    = b_rs;
                    state_d = ST_SETUP;
                    cnt_d   = cyc_load(SETUP_CYC);
                end else if (grant_s[0]) begin
                    d_d     = a_data;
                    rs_d    = a_rs;
                    state_d = ST_SETUP;
                    cnt_d   = cyc_load(SETUP_CYC);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    e_d     = 1'b1;
                    cnt_d   = cyc_load(E_HIGH_CYC);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    e_d     = 1'b0;
                    cnt_d   = cyc_load(HOLD_CYC);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_EXEC;
                    cnt_d   = lcd_is_slow_cmd(rs_q, d_q) ? cyc_load(CLEAR_CYC) : cyc_load(EXEC_CYC);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
`ifdef LCD_SCHED_INIT_EN
                    if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == 2'(LCD_INIT_LEN - 1)) begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_INIT_CMD;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = RESET_ST;
                cnt_d   = CW'(RESET_CNT);
                e_d     = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any strobe in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_ST;
            cnt_q       <= CW'(RESET_CNT);
            d_q         <= 8'h00;
            rs_q        <= 1'b0;
            e_q         <= 1'b0;
            busy_q      <= (RESET_ST != ST_IDLE);
            init_done_q <= 1'b0;
`ifdef LCD_SCHED_INIT_EN
            idx_q       <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            d_q         <= d_d;
            rs_q        <= rs_d;
            e_q         <= e_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
`ifdef LCD_SCHED_INIT_EN
            idx_q       <= idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Scoreboard bench for lcd_bus_scheduler: every expected E pulse (byte, rs and the
// idle tail after it) is queued by the stimulus and checked by an independent monitor.
module tb_lcd_bus_scheduler;

    localparam int SETUP = 2, EHIGH = 4, HOLD = 1, EXEC = 8, CLEAR = 20, IWAIT = 10;
`ifdef LCD_SCHED_INIT_EN
    localparam int INIT_EN = 1;
`else
    localparam int INIT_EN = 0;
`endif
    // Tail = cycles from the e fall to the next rise or to busy dropping.
    localparam int TAIL_IDLE  = 9;   // HOLD 1 + EXEC 8
    localparam int TAIL_CLR   = 21;  // HOLD 1 + CLEAR 20
    localparam int TAIL_INIT  = 12;  // HOLD 1 + EXEC 8 + INIT_CMD 1 + SETUP 2
    localparam int TAIL_INITC = 24;  // HOLD 1 + CLEAR 20 + INIT_CMD 1 + SETUP 2

    logic       clk = 1'b0, reset = 1'b1;
    logic       a_valid = 1'b0, a_rs = 1'b0, b_valid = 1'b0, b_rs = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       a_ready, b_ready, e, rs, busy, init_done;
    logic [7:0] d;

    always #5 clk = ~clk;

    lcd_bus_scheduler #(
        .SETUP_CYC(SETUP), .E_HIGH_CYC(EHIGH), .HOLD_CYC(HOLD),
        .EXEC_CYC(EXEC), .CLEAR_CYC(CLEAR), .INIT_WAIT_CYC(IWAIT)
    ) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_rs(a_rs), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rs(b_rs), .b_data(b_data), .b_ready(b_ready),
        .d(d), .e(e), .rs(rs), .busy(busy), .init_done(init_done)
    );

    typedef struct { logic [7:0] data; logic rs; int tail; } exp_t;
    typedef struct { logic rs; logic [7:0] data; } req_t;

    exp_t exp_q[$];
    int   rise_log[$];
    req_t a_src[$], b_src[$];
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0;
    int   a_acc = 0, b_acc = 0, both_err = 0, early_err = 0, last_acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, got, got, want, want, cyc);
        end
    endtask

    // Monitor: pops one expectation per E pulse, checks byte, rs, width and tail.
    initial begin
        int   ph, width, tail;
        exp_t cur;
        ph = 0; width = 0; tail = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ph = 0;
            end else begin
                if (ph == 2) begin
                    if (e || !busy) begin
                        check("tail_cycles", tail, cur.tail);
                        ph = 0;
                    end else begin
                        tail++;
                    end
                end
                if (ph == 1) begin
                    if (e) begin
                        width++;
                    end else begin
                        check("e_width", width, EHIGH);
                        tail = 1;
                        ph = 2;
                    end
                end else if (ph == 0 && e) begin
                    rise_log.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check("pulse_expected", 0, 1);
                        cur = '{d, rs, -1};
                    end else begin
                        cur = exp_q.pop_front();
                        check("pulse_d", d, cur.data);
                        check("pulse_rs", rs, cur.rs);
                    end
                    width = 1;
                    ph = 1;
                end
            end
        end
    end

    task automatic drive_ports();
        int guard;
        guard = 0;
        while ((a_src.size() > 0 || b_src.size() > 0) && guard < 1000) begin
            a_valid = (a_src.size() > 0);
            if (a_valid) begin a_rs = a_src[0].rs; a_data = a_src[0].data; end
            b_valid = (b_src.size() > 0);
            if (b_valid) begin b_rs = b_src[0].rs; b_data = b_src[0].data; end
            @(negedge clk);
            if (a_ready && b_ready) both_err++;
            if ((a_ready || b_ready) && !init_done) early_err++;
            if (a_valid && a_ready) begin a_src.delete(0); a_acc++; last_acc_cyc = cyc; end
            if (b_valid && b_ready) begin b_src.delete(0); b_acc++; last_acc_cyc = cyc; end
            @(posedge clk); #1;
            guard++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (guard >= 1000) check("drive_timeout", guard, 0);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 500) begin @(negedge clk); g++; end
        if (g >= 500) check("idle_timeout", g, 0);
        @(posedge clk); #1;
    endtask

    task automatic push_init();
        exp_q.push_back('{8'h38, 1'b0, TAIL_INIT});
        exp_q.push_back('{8'h0C, 1'b0, TAIL_INIT});
        exp_q.push_back('{8'h01, 1'b0, TAIL_INITC});
        exp_q.push_back('{8'h06, 1'b0, TAIL_IDLE});
    endtask

    initial begin
        int rel, a0, b0, g;
        // Reset state, with both valids high to show ready is held off.
        a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_d", d, 8'h00);
        check("rst_e", e, 0);
        check("rst_rs", rs, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_init_done", init_done, 0);
        check("rst_busy", busy, INIT_EN);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        `ifdef LCD_SCHED_INIT_EN push_init(); `endif
        reset = 1'b0;
        rel = cyc;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_init_done", init_done, 1 - INIT_EN);
        check("post_rst_busy", busy, INIT_EN);
        @(posedge clk); #1;
`ifdef LCD_SCHED_INIT_EN
        wait_idle();
        check("init_pulses", rise_log.size(), 4);
        if (rise_log.size() > 0) check("init_first_rise", rise_log[0] - rel, IWAIT + 1 + SETUP);
        check("init_done_after", init_done, 1);
`endif

        // Lone A data write 'G': latency and hold of d/rs in IDLE.
        rise_log.delete();
        a0 = a_acc;
        exp_q.push_back('{8'h47, 1'b1, TAIL_IDLE});
        a_src.push_back('{1'b1, 8'h47});
        drive_ports();
        wait_idle();
        check("g_accepts", a_acc - a0, 1);
        check("g_pulses", rise_log.size(), 1);
        if (rise_log.size() > 0) check("g_rise_latency", rise_log[0] - last_acc_cyc, SETUP + 1);
        check("idle_d_hold", d, 8'h47);
        check("idle_rs_hold", rs, 1);

        // B commands: clear and home take the long wait, data 0x01 does not.
        exp_q.push_back('{8'h01, 1'b0, TAIL_CLR});
        exp_q.push_back('{8'h01, 1'b1, TAIL_IDLE});
        exp_q.push_back('{8'h02, 1'b0, TAIL_CLR});
        b_src.push_back('{1'b0, 8'h01});
        b_src.push_back('{1'b1, 8'h01});
        b_src.push_back('{1'b0, 8'h02});
        drive_ports();
        wait_idle();

        // Contention: pointer sits at A after B's lone grants, so A,B,A,B.
        a0 = a_acc; b0 = b_acc;
        exp_q.push_back('{8'h41, 1'b1, TAIL_IDLE});
        exp_q.push_back('{8'h61, 1'b1, TAIL_IDLE});
        exp_q.push_back('{8'h42, 1'b1, TAIL_IDLE});
        exp_q.push_back('{8'h62, 1'b1, TAIL_IDLE});
        a_src.push_back('{1'b1, 8'h41});
        a_src.push_back('{1'b1, 8'h42});
        b_src.push_back('{1'b1, 8'h61});
        b_src.push_back('{1'b1, 8'h62});
        drive_ports();
        wait_idle();
        check("rr_a_accepts", a_acc - a0, 2);
        check("rr_b_accepts", b_acc - b0, 2);

        // Reset on the second e-high cycle, A valid held through reset.
        exp_q.push_back('{8'h33, 1'b1, TAIL_IDLE});
        a_src.push_back('{1'b1, 8'h33});
        drive_ports();
        g = 0;
        @(negedge clk);
        while (!e && g < 50) begin @(negedge clk); g++; end
        check("e_seen_before_reset", e, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h55;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_e", e, 0);
        check("rst_mid_d", d, 8'h00);
        check("rst_mid_busy", busy, INIT_EN);
        check("rst_mid_a_ready", a_ready, 0);
        @(posedge clk); #1;
        `ifdef LCD_SCHED_INIT_EN push_init(); `endif
        exp_q.push_back('{8'h55, 1'b1, TAIL_IDLE});
        reset = 1'b0;
        a_src.push_back('{1'b1, 8'h55});
        drive_ports();
        wait_idle();

        check("exp_q_drained", exp_q.size(), 0);
        check("both_ready", both_err, 0);
        check("ready_before_init", early_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
